// File: rtl/mips_tb_pkg.sv
// Shared types and helpers for the MIPS run monitor: FSM state encoding,
// the default watched data address and a saturating counter increment.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  // Data address whose stores are captured when no override is given.
  localparam logic [31:0] WATCH_ADR_DEFAULT = 32'h0000_07D0;

  // Increment a counter of 'width' bits (<= 32), sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_s;
    if (width >= 32'd32) begin
      max_s = 32'hFFFF_FFFF;
    end else begin
      max_s = (32'd1 << width) - 32'd1;
    end
    if (value >= max_s) begin
      sat_inc = max_s;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/halt_detector.sv
// Halt detector: remembers the previous PC and counts how many consecutive
// samples carried the same PC. A jump-to-self loop shows up as a PC that
// stops moving; 'halted' flags the sample that completes HALT_REPEAT repeats.
module halt_detector
  import mips_tb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic [ADDR_W-1:0] pc,
  output logic              changed,
  output logic              halted
);

  logic              valid_r;
  logic [ADDR_W-1:0] prev_pc_r;
  logic [CNT_W-1:0]  repeat_r;
  logic              changed_s;
  logic [CNT_W-1:0]  repeat_next_s;

  // Change detection and next repeat count; the first sample after a clear always counts as a change.
  always_comb begin
    changed_s = (!valid_r) || (pc != prev_pc_r);
    if (changed_s) begin
      repeat_next_s = CNT_W'(1);
    end else begin
      repeat_next_s = CNT_W'(sat_inc(32'(repeat_r), CNT_W));
    end
  end

  assign changed = changed_s;
  assign halted  = sample && (repeat_next_s >= CNT_W'(HALT_REPEAT));

  // Previous-PC and repeat-count registers, cleared at the start of every run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= 1'b0;
      prev_pc_r <= '0;
      repeat_r  <= '0;
    end else if (clear) begin
      valid_r   <= 1'b0;
      prev_pc_r <= '0;
      repeat_r  <= '0;
    end else if (sample) begin
      valid_r   <= 1'b1;
      prev_pc_r <= pc;
      repeat_r  <= repeat_next_s;
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller and self-checking monitor for a single-cycle MIPS core.
// Sequences the CPU reset, watches the instruction and data buses, stops on
// halt or timeout, and grades the watched store against an expected value.
module mips_run_monitor
  import mips_tb_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 32,
  parameter int              CNT_W        = 16,
  parameter int              RESET_CYCLES = 2,
  parameter int              HALT_REPEAT  = 4,
  parameter int              TIMEOUT      = 512,
  parameter logic [ADDR_W-1:0] WATCH_ADR  = ADDR_W'(WATCH_ADR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] expect_val,
  input  logic [ADDR_W-1:0] inst_adr,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              mem_write,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              watch_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [DATA_W-1:0] watch_val
);

  run_state_e        state_r, state_s;
  logic [CNT_W-1:0]  rst_cnt_r, rst_cnt_s;
  logic [CNT_W-1:0]  cycle_cnt_r, cycle_cnt_s;
  logic [CNT_W-1:0]  inst_cnt_r, inst_cnt_s;
  logic [CNT_W-1:0]  store_cnt_r, store_cnt_s;
  logic [DATA_W-1:0] watch_val_r, watch_val_s;
  logic              watch_hit_r, watch_hit_s;
  logic              timeout_r, timeout_s;
  logic              pass_r, pass_s;
  logic              cpu_rst_r, cpu_rst_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              hd_clear_s, hd_sample_s, pc_changed_s, halted_s;

  assign hd_clear_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign hd_sample_s = (state_r == ST_RUN);

  halt_detector #(
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clk     (clk),
    .rst     (rst),
    .clear   (hd_clear_s),
    .sample  (hd_sample_s),
    .pc      (inst_adr),
    .changed (pc_changed_s),
    .halted  (halted_s)
  );

  // Next-state and next-statistics logic; everything holds unless the current state says otherwise.
  always_comb begin
    state_s     = state_r;
    rst_cnt_s   = rst_cnt_r;
    cycle_cnt_s = cycle_cnt_r;
    inst_cnt_s  = inst_cnt_r;
    store_cnt_s = store_cnt_r;
    watch_val_s = watch_val_r;
    watch_hit_s = watch_hit_r;
    timeout_s   = timeout_r;
    pass_s      = pass_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s     = ST_RESET;
          rst_cnt_s   = '0;
          cycle_cnt_s = '0;
          inst_cnt_s  = '0;
          store_cnt_s = '0;
          watch_val_s = '0;
          watch_hit_s = 1'b0;
          timeout_s   = 1'b0;
          pass_s      = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESET: begin
        if (rst_cnt_r >= CNT_W'(RESET_CYCLES - 1)) begin
          state_s = ST_RUN;
        end else begin
          rst_cnt_s = CNT_W'(sat_inc(32'(rst_cnt_r), CNT_W));
        end
      end
      ST_RUN: begin
        cycle_cnt_s = CNT_W'(sat_inc(32'(cycle_cnt_r), CNT_W));
        if (pc_changed_s) begin
          inst_cnt_s = CNT_W'(sat_inc(32'(inst_cnt_r), CNT_W));
        end else begin
          inst_cnt_s = inst_cnt_r;
        end
        if (mem_write) begin
          store_cnt_s = CNT_W'(sat_inc(32'(store_cnt_r), CNT_W));
        end else begin
          store_cnt_s = store_cnt_r;
        end
        if (mem_write && (data_adr == WATCH_ADR)) begin
          watch_val_s = data_wr;
          watch_hit_s = 1'b1;
        end else begin
          watch_val_s = watch_val_r;
        end
        // A halt on the timeout cycle is a genuine finish, so it takes priority.
        if (halted_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b0;
          pass_s    = watch_hit_s && (watch_val_s == expect_val);
        end else if (cycle_cnt_s >= CNT_W'(TIMEOUT - 1)) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
          pass_s    = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    cpu_rst_s = (state_s == ST_IDLE) || (state_s == ST_RESET);
    busy_s    = (state_s == ST_RESET) || (state_s == ST_RUN);
    done_s    = (state_s == ST_DONE);
  end

  // State, statistics and status flags all update together on the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rst_cnt_r   <= '0;
      cycle_cnt_r <= '0;
      inst_cnt_r  <= '0;
      store_cnt_r <= '0;
      watch_val_r <= '0;
      watch_hit_r <= 1'b0;
      timeout_r   <= 1'b0;
      pass_r      <= 1'b0;
      cpu_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      rst_cnt_r   <= rst_cnt_s;
      cycle_cnt_r <= cycle_cnt_s;
      inst_cnt_r  <= inst_cnt_s;
      store_cnt_r <= store_cnt_s;
      watch_val_r <= watch_val_s;
      watch_hit_r <= watch_hit_s;
      timeout_r   <= timeout_s;
      pass_r      <= pass_s;
      cpu_rst_r   <= cpu_rst_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign cpu_rst   = cpu_rst_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign timeout   = timeout_r;
  assign watch_hit = watch_hit_r;
  assign cycle_cnt = cycle_cnt_r;
  assign inst_cnt  = inst_cnt_r;
  assign store_cnt = store_cnt_r;
  assign watch_val = watch_val_r;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor. Each run pushes its hand-derived
// expected outcome onto a queue; the entry is popped and compared when the
// monitor reports done.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] expect_val = 32'h0;
  logic [31:0] inst_adr = 32'h0;
  logic [31:0] data_adr = 32'h0;
  logic [31:0] data_wr = 32'h0;
  logic        mem_write = 1'b0;
  logic        cpu_rst, busy, done, pass, timeout, watch_hit;
  logic [15:0] cycle_cnt, inst_cnt, store_cnt;
  logic [31:0] watch_val;

  typedef struct {
    string       tag;
    int          cycles;
    int          inst;
    int          stores;
    logic        hit;
    logic [31:0] val;
    logic        to;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mips_run_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .expect_val (expect_val),
    .inst_adr   (inst_adr),
    .data_adr   (data_adr),
    .data_wr    (data_wr),
    .mem_write  (mem_write),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .watch_hit  (watch_hit),
    .cycle_cnt  (cycle_cnt),
    .inst_cnt   (inst_cnt),
    .store_cnt  (store_cnt),
    .watch_val  (watch_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Pulse start and follow the reset sequence into the first RUN cycle.
  task automatic start_run(input string tag, input logic [31:0] ev);
    expect_val = ev;
    inst_adr   = 32'h0;
    mem_write  = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(tag, "reset1_cpu_rst", 32'(cpu_rst), 32'd1);
    chk(tag, "reset1_busy", 32'(busy), 32'd1);
    chk(tag, "reset1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk(tag, "reset2_cpu_rst", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk(tag, "run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk(tag, "run_busy", 32'(busy), 32'd1);
    chk(tag, "run_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk(tag, "run_inst_cnt", 32'(inst_cnt), 32'd0);
    chk(tag, "run_store_cnt", 32'(store_cnt), 32'd0);
    chk(tag, "run_watch_hit", 32'(watch_hit), 32'd0);
    chk(tag, "run_watch_val", watch_val, 32'd0);
  endtask

  // PC walks 0,4,.. for n_chg cycles then holds; one store at st_idx; optional start pulse at start_idx.
  task automatic run_prog(input int n_chg, input int st_idx, input logic [31:0] st_adr,
                          input logic [31:0] st_dat, input int start_idx);
    exp_t e;
    int   steps;
    bit   seen;
    steps = 0;
    seen  = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      inst_adr  = 32'(4 * ((i < n_chg) ? i : n_chg - 1));
      mem_write = (i == st_idx);
      data_adr  = (i == st_idx) ? st_adr : 32'h0;
      data_wr   = (i == st_idx) ? st_dat : 32'h0;
      start     = (i == start_idx);
      @(negedge clk);
      steps++;
      if (done) seen = 1'b1;
    end
    mem_write = 1'b0;
    start     = 1'b0;
    e = exp_q.pop_front();
    chk(e.tag, "done_seen", 32'(seen), 32'd1);
    chk(e.tag, "run_cycles", 32'(steps), 32'(e.cycles));
    chk(e.tag, "cycle_cnt", 32'(cycle_cnt), 32'(e.cycles));
    chk(e.tag, "inst_cnt", 32'(inst_cnt), 32'(e.inst));
    chk(e.tag, "store_cnt", 32'(store_cnt), 32'(e.stores));
    chk(e.tag, "watch_hit", 32'(watch_hit), 32'(e.hit));
    chk(e.tag, "watch_val", watch_val, e.val);
    chk(e.tag, "timeout", 32'(timeout), 32'(e.to));
    chk(e.tag, "pass", 32'(pass), 32'(e.pass));
    chk(e.tag, "busy", 32'(busy), 32'd0);
    // Bus activity while DONE must not disturb anything.
    inst_adr  = 32'h0000_DEAD;
    mem_write = 1'b1;
    data_adr  = 32'h0000_07D0;
    data_wr   = 32'h0000_FFFF;
    @(negedge clk);
    mem_write = 1'b0;
    chk(e.tag, "hold_done", 32'(done), 32'd1);
    chk(e.tag, "hold_cycle_cnt", 32'(cycle_cnt), 32'(e.cycles));
    chk(e.tag, "hold_store_cnt", 32'(store_cnt), 32'(e.stores));
    chk(e.tag, "hold_watch_val", watch_val, e.val);
  endtask

  initial begin
    // Power-on reset state.
    repeat (2) @(negedge clk);
    chk("por", "cpu_rst", 32'(cpu_rst), 32'd1);
    chk("por", "busy", 32'(busy), 32'd0);
    chk("por", "done", 32'(done), 32'd0);
    chk("por", "cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("por", "watch_val", watch_val, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle", "cpu_rst", 32'(cpu_rst), 32'd1);

    // PC 0..40 then hold at 40 (11 distinct PCs, halt after 4 samples of 40), store 0x37 matches.
    exp_q.push_back('{"halt_pass", 14, 11, 1, 1'b1, 32'h37, 1'b0, 1'b1});
    start_run("halt_pass", 32'h37);
    run_prog(11, 2, 32'h0000_07D0, 32'h0000_0037, -1);

    // Same program, expected value differs; restarted straight from DONE.
    exp_q.push_back('{"halt_mismatch", 14, 11, 1, 1'b1, 32'h37, 1'b0, 1'b0});
    start_run("halt_mismatch", 32'h38);
    run_prog(11, 2, 32'h0000_07D0, 32'h0000_0037, -1);

    // Store to a neighbouring address only, plus a start pulse mid-RUN that must be ignored.
    exp_q.push_back('{"other_adr", 14, 11, 1, 1'b0, 32'h0, 1'b0, 1'b0});
    start_run("other_adr", 32'h37);
    run_prog(11, 2, 32'h0000_07D4, 32'h0000_0037, 5);

    // PC never stops: forced finish at cycle 511, matching store still fails.
    exp_q.push_back('{"timeout", 511, 511, 1, 1'b1, 32'h37, 1'b1, 1'b0});
    start_run("timeout", 32'h37);
    run_prog(100000, 3, 32'h0000_07D0, 32'h0000_0037, -1);

    // Halt completes on cycle 511 together with the timeout; store lands in that final cycle.
    exp_q.push_back('{"halt_at_timeout", 511, 508, 1, 1'b1, 32'h55, 1'b0, 1'b1});
    start_run("halt_at_timeout", 32'h55);
    run_prog(508, 510, 32'h0000_07D0, 32'h0000_0055, -1);

    // Asynchronous reset between clock edges in the middle of a run.
    start_run("async_rst", 32'h0);
    for (int i = 0; i < 5; i++) begin
      inst_adr  = 32'(4 * i);
      mem_write = (i == 1);
      data_adr  = 32'h0000_07D0;
      data_wr   = 32'h0000_0011;
      @(negedge clk);
    end
    mem_write = 1'b0;
    chk("async_rst", "pre_cycle_cnt", 32'(cycle_cnt), 32'd5);
    chk("async_rst", "pre_watch_hit", 32'(watch_hit), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", "cpu_rst", 32'(cpu_rst), 32'd1);
    chk("async_rst", "busy", 32'(busy), 32'd0);
    chk("async_rst", "cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("async_rst", "inst_cnt", 32'(inst_cnt), 32'd0);
    chk("async_rst", "store_cnt", 32'(store_cnt), 32'd0);
    chk("async_rst", "watch_hit", 32'(watch_hit), 32'd0);
    chk("async_rst", "watch_val", watch_val, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
